// File: rtl/soc_bus_arbiter_pkg.sv
// Shared types and constants for the SoC bus arbiter.
// Bus widths, idle words, strobe levels and FSM states.
package soc_bus_arbiter_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  localparam int DATA_BUS_WIDTH = 32;
  localparam int N_MASTERS      = 4;

  localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_BUS_WIDTH-1:0] ZERO_ADDR = '0;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic logic [3:0] onehot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/soc_bus_arbiter_rr_pick.sv
// Round-robin winner select over four requesters.
// Scans last+1, last+2, ... wrapping, last itself is checked last.
module soc_rr_pick
  import soc_bus_arbiter_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] win_o,
  output logic       found_o
);

  logic [1:0] idx;

  // farthest candidate first so the nearest requester overwrites it
  always_comb begin
    win_o   = 2'd0;
    found_o = 1'b0;
    idx     = 2'd0;
    for (int d = 4; d >= 1; d--) begin
      idx = last_i + 2'(d);
      if (req_i[idx]) begin
        win_o   = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Four-master round-robin arbiter for the SoC system bus.
// Grant hold with optional preemption after MAX_HOLD cycles.
module soc_bus_arbiter
  import soc_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req_i,
  input  logic [ADDR_BUS_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] m0_data_i,
  input  logic                      m0_we_i,
  input  logic                      m0_rd_i,
  output logic                      m0_gnt_o,
  output logic [DATA_BUS_WIDTH-1:0] m0_data_o,
  input  logic                      m1_req_i,
  input  logic [ADDR_BUS_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] m1_data_i,
  input  logic                      m1_we_i,
  input  logic                      m1_rd_i,
  output logic                      m1_gnt_o,
  output logic [DATA_BUS_WIDTH-1:0] m1_data_o,
  input  logic                      m2_req_i,
  input  logic [ADDR_BUS_WIDTH-1:0] m2_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] m2_data_i,
  input  logic                      m2_we_i,
  input  logic                      m2_rd_i,
  output logic                      m2_gnt_o,
  output logic [DATA_BUS_WIDTH-1:0] m2_data_o,
  input  logic                      m3_req_i,
  input  logic [ADDR_BUS_WIDTH-1:0] m3_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] m3_data_i,
  input  logic                      m3_we_i,
  input  logic                      m3_rd_i,
  output logic                      m3_gnt_o,
  output logic [DATA_BUS_WIDTH-1:0] m3_data_o,
  output logic [ADDR_BUS_WIDTH-1:0] b_addr_o,
  output logic [DATA_BUS_WIDTH-1:0] b_data_o,
  output logic                      b_we_o,
  output logic                      b_rd_o,
  input  logic [DATA_BUS_WIDTH-1:0] b_data_i,
  output logic [1:0]                owner_o,
  output logic                      busy_o
);

  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : '1;

  logic [3:0]                req;
  logic [3:0]                we;
  logic [3:0]                rd;
  logic [ADDR_BUS_WIDTH-1:0] addr [N_MASTERS];
  logic [DATA_BUS_WIDTH-1:0] wdat [N_MASTERS];

  arb_state_e  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic        busy;
  logic        own_req;
  logic [3:0]  pick_req;
  logic [1:0]  pick_last;
  logic [1:0]  win;
  logic        found;

  assign req = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
  assign we  = {m3_we_i, m2_we_i, m1_we_i, m0_we_i};
  assign rd  = {m3_rd_i, m2_rd_i, m1_rd_i, m0_rd_i};

  assign addr[0] = m0_addr_i;
  assign addr[1] = m1_addr_i;
  assign addr[2] = m2_addr_i;
  assign addr[3] = m3_addr_i;
  assign wdat[0] = m0_data_i;
  assign wdat[1] = m1_data_i;
  assign wdat[2] = m2_data_i;
  assign wdat[3] = m3_data_i;

  assign busy    = (state_q == OWN);
  assign own_req = req[owner_q];

  // while owning, rotate from the owner and exclude it;
  // while idle, rotate from the last released master
  always_comb begin
    pick_req  = req;
    pick_last = last_q;
    if (busy) begin
      pick_req  = req & ~onehot4(owner_q);
      pick_last = owner_q;
    end
  end

  soc_rr_pick u_pick (
    .req_i   (pick_req),
    .last_i  (pick_last),
    .win_o   (win),
    .found_o (found)
  );

  // arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // grant, release, preempt and hold counting
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          owner_d = win;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (!own_req) begin
          last_d = owner_q;
          hold_d = '0;
          if (found) begin
            owner_d = win;
          end else begin
            state_d = IDLE;
          end
        end else if (PREEMPT_EN &&
                     hold_q == HOLD_LIM &&
                     found) begin
          last_d  = owner_q;
          owner_d = win;
          hold_d  = '0;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  // bus-side mux; strobes gated by the owner's live request
  always_comb begin
    b_addr_o = ZERO_ADDR;
    b_data_o = ZERO_WORD;
    b_we_o   = INVALID;
    b_rd_o   = INVALID;
    if (busy) begin
      b_addr_o = addr[owner_q];
      b_data_o = wdat[owner_q];
      b_we_o   = own_req & we[owner_q];
      b_rd_o   = own_req & rd[owner_q];
    end
  end

  // read return and grant decode
  always_comb begin
    m0_data_o = ZERO_WORD;
    m1_data_o = ZERO_WORD;
    m2_data_o = ZERO_WORD;
    m3_data_o = ZERO_WORD;
    m0_gnt_o  = 1'b0;
    m1_gnt_o  = 1'b0;
    m2_gnt_o  = 1'b0;
    m3_gnt_o  = 1'b0;
    if (busy) begin
      unique case (owner_q)
        2'd0: begin m0_gnt_o = 1'b1; m0_data_o = b_data_i; end
        2'd1: begin m1_gnt_o = 1'b1; m1_data_o = b_data_i; end
        2'd2: begin m2_gnt_o = 1'b1; m2_data_o = b_data_i; end
        2'd3: begin m3_gnt_o = 1'b1; m3_data_o = b_data_i; end
      endcase
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = busy;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Bench for soc_bus_arbiter: MAX_HOLD=16 and MAX_HOLD=0 builds.
// Vector table, directed sequences, random run vs. reference model.
module tb_soc_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, we, rd;
  logic [31:0] addr [4];
  logic [31:0] wdat [4];
  logic [31:0] bdi;

  logic [3:0]  ga, gb;
  logic [31:0] doa [4];
  logic [31:0] dob [4];
  logic [31:0] ba_addr, ba_data, bb_addr, bb_data;
  logic        ba_we, ba_rd, bb_we, bb_rd;
  logic [1:0]  oa, ob;
  logic        busya, busyb;

  int vec;
  int bad;

  int mb [2];
  int mo [2];
  int ml [2];
  int mh [2];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  soc_bus_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_data_i(wdat[0]),
    .m0_we_i(we[0]), .m0_rd_i(rd[0]),
    .m0_gnt_o(ga[0]), .m0_data_o(doa[0]),
    .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_data_i(wdat[1]),
    .m1_we_i(we[1]), .m1_rd_i(rd[1]),
    .m1_gnt_o(ga[1]), .m1_data_o(doa[1]),
    .m2_req_i(req[2]), .m2_addr_i(addr[2]), .m2_data_i(wdat[2]),
    .m2_we_i(we[2]), .m2_rd_i(rd[2]),
    .m2_gnt_o(ga[2]), .m2_data_o(doa[2]),
    .m3_req_i(req[3]), .m3_addr_i(addr[3]), .m3_data_i(wdat[3]),
    .m3_we_i(we[3]), .m3_rd_i(rd[3]),
    .m3_gnt_o(ga[3]), .m3_data_o(doa[3]),
    .b_addr_o(ba_addr), .b_data_o(ba_data),
    .b_we_o(ba_we), .b_rd_o(ba_rd), .b_data_i(bdi),
    .owner_o(oa), .busy_o(busya)
  );

  soc_bus_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_data_i(wdat[0]),
    .m0_we_i(we[0]), .m0_rd_i(rd[0]),
    .m0_gnt_o(gb[0]), .m0_data_o(dob[0]),
    .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_data_i(wdat[1]),
    .m1_we_i(we[1]), .m1_rd_i(rd[1]),
    .m1_gnt_o(gb[1]), .m1_data_o(dob[1]),
    .m2_req_i(req[2]), .m2_addr_i(addr[2]), .m2_data_i(wdat[2]),
    .m2_we_i(we[2]), .m2_rd_i(rd[2]),
    .m2_gnt_o(gb[2]), .m2_data_o(dob[2]),
    .m3_req_i(req[3]), .m3_addr_i(addr[3]), .m3_data_i(wdat[3]),
    .m3_we_i(we[3]), .m3_rd_i(rd[3]),
    .m3_gnt_o(gb[3]), .m3_data_o(dob[3]),
    .b_addr_o(bb_addr), .b_data_o(bb_data),
    .b_we_o(bb_we), .b_rd_o(bb_rd), .b_data_i(bdi),
    .owner_o(ob), .busy_o(busyb)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mb[k] = 0;
      mo[k] = 0;
      ml[k] = 3;
      mh[k] = 0;
    end
  endtask

  // next requester after 'from' going round, excluding 'from'
  // unless incl is set (then 'from' is the final candidate)
  function automatic int next_req(input logic [3:0] r,
                                  input int from,
                                  input bit incl);
    int n;
    n = incl ? 4 : 3;
    for (int d = 1; d <= n; d++)
      if (r[(from + d) % 4]) return (from + d) % 4;
    return -1;
  endfunction

  // one clock edge of arbitration, from the rules
  task automatic model_step(input int k, input int maxh,
                            input logic [3:0] r);
    int w;
    if (mb[k] == 0) begin
      w = next_req(r, ml[k], 1'b1);
      if (w >= 0) begin
        mb[k] = 1; mo[k] = w; mh[k] = 0;
      end
    end else if (!r[mo[k]]) begin
      ml[k] = mo[k];
      w = next_req(r, mo[k], 1'b0);
      mh[k] = 0;
      if (w >= 0) mo[k] = w;
      else mb[k] = 0;
    end else begin
      w = next_req(r, mo[k], 1'b0);
      if (maxh != 0 && mh[k] == maxh - 1 && w >= 0) begin
        ml[k] = mo[k]; mo[k] = w; mh[k] = 0;
      end else if (maxh == 0 || mh[k] < maxh - 1) begin
        mh[k] = mh[k] + 1;
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int k);
    return (mb[k] != 0) ? 4'(1 << mo[k]) : 4'b0000;
  endfunction

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    we    = '0;
    rd    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_datapath();
    logic [31:0] ea, ed;
    logic        ew, er;
    ea = 0; ed = 0; ew = 0; er = 0;
    if (mb[0] != 0) begin
      ea = addr[mo[0]];
      ed = wdat[mo[0]];
      ew = req[mo[0]] & we[mo[0]];
      er = req[mo[0]] & rd[mo[0]];
    end
    chk("rnd_b_addr", ba_addr, ea);
    chk("rnd_b_data", ba_data, ed);
    chk("rnd_b_we", 32'(ba_we), 32'(ew));
    chk("rnd_b_rd", 32'(ba_rd), 32'(er));
    for (int i = 0; i < 4; i++)
      chk("rnd_data_o", doa[i],
          (mb[0] != 0 && mo[0] == i) ? bdi : 32'h0);
  endtask

  initial begin
    int          cnt;
    int          idle;
    int          gc [4];
    int          order [$];
    logic [3:0]  r;

    vec = 0;
    bad = 0;
    rst_n = 1'b0;
    req = '0; we = '0; rd = '0; bdi = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      wdat[i] = 32'hA000_0000 + 32'(i);
    end
    model_reset();

    // reset with all masters requesting and writing
    req = 4'b1111;
    we  = 4'b1111;
    rd  = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", 32'(ga), 32'h0);
    chk("rst_gnt_b", 32'(gb), 32'h0);
    chk("rst_b_we", 32'(ba_we), 32'h0);
    chk("rst_b_rd", 32'(ba_rd), 32'h0);
    chk("rst_b_addr", ba_addr, 32'h0);
    chk("rst_busy", 32'(busya), 32'h0);
    chk("rst_owner", 32'(oa), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_gnt0", 32'(ga), 32'h1);

    // vector table: cycle-by-cycle from reset
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0100};
    tbl[2] = '{4'b0110, 4'b0100};
    tbl[3] = '{4'b0010, 4'b0010};
    tbl[4] = '{4'b1011, 4'b0010};
    tbl[5] = '{4'b1001, 4'b1000};
    tbl[6] = '{4'b0001, 4'b0001};
    tbl[7] = '{4'b0000, 4'b0000};
    tbl[8] = '{4'b1111, 4'b0010};
    tbl[9] = '{4'b1101, 4'b0100};
    do_reset(4'b0000);
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_gnt_a", i), 32'(ga), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_gnt_b", i), 32'(gb), 32'(tbl[i].gnt));
      @(negedge clk);
    end

    // single master write through m2
    do_reset(4'b0000);
    addr[2] = 32'h1000_0010;
    wdat[2] = 32'hDEAD_BEEF;
    we[2]   = 1'b1;
    req[2]  = 1'b1;
    @(posedge clk);
    #1;
    chk("s2_gnt", 32'(ga), 32'h4);
    chk("s2_owner", 32'(oa), 32'h2);
    chk("s2_addr", ba_addr, 32'h1000_0010);
    chk("s2_we", 32'(ba_we), 32'h1);
    chk("s2_data", ba_data, 32'hDEAD_BEEF);
    @(negedge clk);
    req[2] = 1'b0;
    #1;
    chk("s2_we_drop", 32'(ba_we), 32'h0);
    chk("s2_gnt_hold", 32'(ga), 32'h4);
    @(posedge clk);
    #1;
    chk("s2_gnt_rel", 32'(ga), 32'h0);
    we[2] = 1'b0;

    // read return to m1
    @(negedge clk);
    req[1] = 1'b1;
    rd[1]  = 1'b1;
    bdi    = 32'h0000_00A5;
    @(posedge clk);
    #1;
    chk("rd_gnt", 32'(ga), 32'h2);
    chk("rd_b_rd", 32'(ba_rd), 32'h1);
    chk("rd_m1", doa[1], 32'hA5);
    chk("rd_m0", doa[0], 32'h0);
    chk("rd_m2", doa[2], 32'h0);
    chk("rd_m3", doa[3], 32'h0);
    @(negedge clk);
    req = '0; rd = '0;

    // all four at once, each keeps the bus 3 cycles
    do_reset(4'b1111);
    for (int i = 0; i < 4; i++) gc[i] = 0;
    order.delete();
    idle = 0;
    cnt  = 0;
    while (!(gc[3] >= 3 && !busya) && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (busya) begin
        gc[oa]++;
        if (order.size() == 0 || order[$] != int'(oa))
          order.push_back(int'(oa));
      end else if (order.size() > 0 && order.size() < 4) begin
        idle++;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (ga[i] && gc[i] == 3) req[i] = 1'b0;
    end
    chk("rr_timeout", 32'(cnt < 40), 32'h1);
    chk("rr_count", 32'(order.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
          32'(i));
      chk("rr_cycles", 32'(gc[i]), 32'h3);
    end
    chk("rr_idle", 32'(idle), 32'h0);

    // preemption: m1 held, m3 joins later
    do_reset(4'b0000);
    req[1] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 4) begin
        @(negedge clk);
        req[3] = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ga[3]) break;
      if (ga[1]) cnt++;
    end
    chk("pre_gnt3", 32'(ga), 32'h8);
    chk("pre_hold16", 32'(cnt), 32'd16);
    chk("pre_b_keep", 32'(gb), 32'h2);
    @(negedge clk);
    req[3] = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_back1", 32'(ga), 32'h2);
    chk("pre_b_still", 32'(gb), 32'h2);
    @(negedge clk);
    req = '0;

    // async reset during an m0 write burst
    do_reset(4'b0000);
    req[0] = 1'b1;
    we[0]  = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_gnt0", 32'(ga), 32'h1);
    chk("ar_we", 32'(ba_we), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_drop", 32'(ga), 32'h0);
    chk("ar_we_drop", 32'(ba_we), 32'h0);
    req = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_m1", 32'(ga), 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_m0_first", 32'(ga), 32'h1);

    // random traffic against the reference model
    do_reset(4'b0000);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ($urandom_range(31) == 0) req[i] = 1'b0;
        end else begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end
        we[i]   = 1'($urandom);
        rd[i]   = 1'($urandom);
        addr[i] = $urandom;
        wdat[i] = $urandom;
      end
      bdi = $urandom;
      #1;
      check_datapath();
      r = req;
      @(posedge clk);
      model_step(0, 16, r);
      model_step(1, 0, r);
      #1;
      chk("rnd_gnt_a", 32'(ga), 32'(exp_gnt(0)));
      chk("rnd_gnt_b", 32'(gb), 32'(exp_gnt(1)));
      chk("rnd_busy_a", 32'(busya), 32'(mb[0] != 0));
      if (mb[0] != 0) chk("rnd_owner_a", 32'(oa), 32'(mo[0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
